// File: rtl/amo_arbiter.sv
// rtl/amo_arbiter.sv - round-robin arbiter funnelling NUM_PORTS AMO requesters onto one cache port
// Optional ack watchdog enabled by defining AMO_ARBITER_TIMEOUT_EN.

package ariane_pkg;
   typedef enum logic [3:0] {
      AMO_NONE, AMO_LR, AMO_SC, AMO_SWAP, AMO_ADD, AMO_AND, AMO_OR,
      AMO_XOR, AMO_MAX, AMO_MAXU, AMO_MIN, AMO_MINU, AMO_CAS1, AMO_CAS2
   } amo_t;

   typedef struct packed {
      logic        req;
      amo_t        amo_op;
      logic [1:0]  size;
      logic [63:0] operand_a;
      logic [63:0] operand_b;
   } amo_req_t;

   typedef struct packed {
      logic        ack;
      logic [63:0] result;
   } amo_resp_t;
endpackage

module amo_arbiter #(
   parameter int unsigned NUM_PORTS      = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  ariane_pkg::amo_req_t  [NUM_PORTS-1:0] amo_req_i,
   output ariane_pkg::amo_resp_t [NUM_PORTS-1:0] amo_resp_o,
   output ariane_pkg::amo_req_t                  amo_req_o,
   input  ariane_pkg::amo_resp_t                 amo_resp_i,
   output logic                                  busy_o,
   output logic                                  timeout_o
);
   localparam int unsigned IDX_W = $clog2(NUM_PORTS);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [IDX_W-1:0]     r_rr_ptr;
   logic [IDX_W-1:0]     r_winner;
   ariane_pkg::amo_req_t r_payload;
   logic [IDX_W-1:0]     w_grant_idx;
   logic [IDX_W-1:0]     w_cand;
   logic                 w_grant_vld;
   logic                 w_take;
   logic                 w_ack;

   function automatic logic [IDX_W-1:0] f_wrap_add(input logic [IDX_W-1:0] base,
                                                   input int unsigned      off);
      int unsigned sum;
      sum = {{(32-IDX_W){1'b0}}, base} + off;
      if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
      return sum[IDX_W-1:0];
   endfunction

   // First requester at or after rr_ptr wins.
   always_comb begin
      w_grant_vld = 1'b0;
      w_grant_idx = r_rr_ptr;
      w_cand      = r_rr_ptr;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         w_cand = f_wrap_add(r_rr_ptr, i);
         if (!w_grant_vld && amo_req_i[w_cand].req) begin
            w_grant_vld = 1'b1;
            w_grant_idx = w_cand;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_take      = 1'b0;
      w_ack       = 1'b0;
      amo_req_o   = '0;
      amo_resp_o  = '0;
      busy_o      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_grant_vld) begin
               w_take      = 1'b1;
               w_state_nxt = S_BUSY;
            end
         end
         S_BUSY: begin
            busy_o        = 1'b1;
            amo_req_o     = r_payload;
            amo_req_o.req = 1'b1;
            if (amo_resp_i.ack) begin
               w_ack                       = 1'b1;
               amo_resp_o[r_winner].ack    = 1'b1;
               amo_resp_o[r_winner].result = amo_resp_i.result;
               w_state_nxt                 = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Payload is captured once at grant; later requester changes are ignored.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_rr_ptr  <= '0;
         r_winner  <= '0;
         r_payload <= '0;
      end else begin
         if (w_take) begin
            r_winner  <= w_grant_idx;
            r_payload <= amo_req_i[w_grant_idx];
         end
         if (w_ack) r_rr_ptr <= f_wrap_add(r_winner, 1);
      end
   end

`ifdef AMO_ARBITER_TIMEOUT_EN
   logic [15:0] r_wd_cnt;
   logic        r_timeout;

   // Counter saturates at the limit; the flag is sticky until reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wd_cnt  <= '0;
         r_timeout <= 1'b0;
      end else if (w_take) begin
         r_wd_cnt <= '0;
      end else if (r_state == S_BUSY && !amo_resp_i.ack) begin
         if (r_wd_cnt == 16'(TIMEOUT_CYCLES - 1)) r_timeout <= 1'b1;
         else                                     r_wd_cnt  <= r_wd_cnt + 16'd1;
      end
   end

   assign timeout_o = r_timeout;
`else
   assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_amo_arbiter.sv
// tb/tb_amo_arbiter.sv - scoreboard bench for amo_arbiter with randomized requesters

module tb_amo_arbiter;
   import ariane_pkg::*;

   localparam int N   = 3;
   localparam int TMO = 8;

   logic                  clk = 1'b0;
   logic                  rst;
   amo_req_t  [N-1:0]     req_in;
   amo_resp_t [N-1:0]     resp_out;
   amo_req_t              req_out;
   amo_resp_t             resp_in;
   logic                  busy;
   logic                  tmo;

   always #5 clk = ~clk;

   amo_arbiter #(.NUM_PORTS(N), .TIMEOUT_CYCLES(TMO)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .amo_req_i  (req_in),
      .amo_resp_o (resp_out),
      .amo_req_o  (req_out),
      .amo_resp_i (resp_in),
      .busy_o     (busy),
      .timeout_o  (tmo)
   );

   typedef struct { amo_req_t pl; int cyc; } grant_t;
   typedef struct { int port; logic [63:0] res; } ack_t;

   int       n_cmp = 0;
   int       n_err = 0;
   int       cyc   = 0;
   bit       rand_on = 0;
   amo_req_t port_req [N];
   bit       clear_next [N];

   // reference model: transaction-level view of the arbiter
   bit       m_busy, m_tmo;
   int       m_rr, m_winner, m_wd;
   bit       cur_busy, cur_tmo;
   grant_t   grant_q[$];
   ack_t     ack_q[$];
   grant_t   cur_g;
   bit       have_g = 0;

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic amo_req_t rand_payload();
      amo_req_t p;
      p.req       = 1'b1;
      p.amo_op    = amo_t'(4'($urandom_range(0, 13)));
      p.size      = 2'($urandom_range(0, 3));
      p.operand_a = {$urandom, $urandom};
      p.operand_b = {$urandom, $urandom};
      return p;
   endfunction

   task automatic cycle(input bit do_ack, input logic [63:0] res);
      int r;
      @(posedge clk);
      #1;
      cyc++;
      for (int n = 0; n < N; n++) begin
         if (clear_next[n]) begin
            port_req[n].req = 1'b0;
            clear_next[n]   = 1'b0;
         end else if (rand_on) begin
            r = $urandom_range(0, 99);
            if (!port_req[n].req) begin
               if (r < 30) port_req[n] = rand_payload();
            end else if (r < 5) begin
               port_req[n].req = 1'b0;
            end else if (r < 15) begin
               port_req[n] = rand_payload();
            end
         end
         req_in[n] = port_req[n];
      end
      resp_in.ack    = do_ack;
      resp_in.result = res;
      cur_busy = m_busy;
      cur_tmo  = m_tmo;
      if (m_busy) begin
         if (do_ack) begin
            ack_q.push_back('{m_winner, res});
            m_rr   = (m_winner + 1) % N;
            m_busy = 0;
            clear_next[m_winner] = 1'b1;
         end else begin
`ifdef AMO_ARBITER_TIMEOUT_EN
            m_wd++;
            if (m_wd >= TMO) m_tmo = 1;
`endif
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            int k;
            k = (m_rr + i) % N;
            if (port_req[k].req) begin
               m_winner = k;
               grant_q.push_back('{port_req[k], cyc});
               m_busy = 1;
               m_wd   = 0;
               break;
            end
         end
      end
   endtask

   always @(negedge clk) begin
      int          n_acks;
      int          ap;
      logic [63:0] ar;
      ack_t        e;
      if (rst) begin
         have_g = 0;
      end else begin
         check("busy_o", busy, cur_busy);
         check("timeout_o", tmo, cur_tmo);
         if (req_out.req) begin
            if (!have_g) begin
               if (grant_q.size() == 0) begin
                  check("unexpected_grant", req_out, 0);
               end else begin
                  cur_g  = grant_q.pop_front();
                  have_g = 1;
                  check("grant_latency", cur_g.cyc, cyc - 1);
                  check("grant_payload", req_out, cur_g.pl);
               end
            end else begin
               check("busy_payload_stable", req_out, cur_g.pl);
            end
         end else begin
            check("idle_req_zero", req_out, 0);
            if (grant_q.size() > 0 && grant_q[0].cyc < cyc) begin
               check("missing_grant", 0, 1);
               void'(grant_q.pop_front());
            end
         end
         n_acks = 0;
         ap     = 0;
         ar     = '0;
         for (int n = 0; n < N; n++) begin
            if (resp_out[n].ack) begin
               n_acks++;
               ap = n;
               ar = resp_out[n].result;
            end else if (resp_out[n].result !== 64'd0) begin
               check("result_without_ack", resp_out[n].result, 0);
            end
         end
         if (n_acks > 0) begin
            check("single_ack", n_acks, 1);
            if (ack_q.size() == 0) begin
               check("spurious_ack", n_acks, 0);
            end else begin
               e = ack_q.pop_front();
               check("ack_port", ap, e.port);
               check("ack_result", ar, e.res);
            end
            have_g = 0;
         end else if (ack_q.size() > 0) begin
            check("missing_ack", 0, 1);
            void'(ack_q.pop_front());
            have_g = 0;
         end
      end
   end

   initial begin
      rst     = 1'b1;
      req_in  = '0;
      resp_in = '0;
      for (int n = 0; n < N; n++) begin
         port_req[n]   = '0;
         clear_next[n] = 1'b0;
      end
      m_busy = 0; m_tmo = 0; m_rr = 0; m_winner = 0; m_wd = 0;
      cur_busy = 0; cur_tmo = 0;
      #2;
      check("reset_req_o", req_out, 0);
      check("reset_resp_o", resp_out, 0);
      check("reset_busy", busy, 0);
      check("reset_timeout", tmo, 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // single AMOSWAP on port 0, ack one cycle after req
      port_req[0]           = '0;
      port_req[0].req       = 1'b1;
      port_req[0].amo_op    = AMO_SWAP;
      port_req[0].size      = 2'd3;
      port_req[0].operand_a = 64'h8000_0000;
      port_req[0].operand_b = 64'h5;
      cycle(0, 64'd0);
      cycle(1, 64'h1234);
      cycle(0, 64'd0);
      cycle(1, 64'hdead);                 // spurious ack while idle

      // port 1 alone, payload churns during a 5-cycle ack hold-off
      port_req[1] = rand_payload();
      cycle(0, 64'd0);
      for (int i = 0; i < 5; i++) begin
         port_req[1] = rand_payload();
         cycle(0, 64'd0);
      end
      cycle(1, {$urandom, $urandom});
      cycle(0, 64'd0);

      // long stall on port 2, exercises the watchdog when built in
      port_req[2] = rand_payload();
      cycle(0, 64'd0);
      for (int i = 0; i < 10; i++) cycle(0, 64'd0);
      cycle(1, {$urandom, $urandom});
      cycle(0, 64'd0);

      // all ports contending
      for (int t = 0; t < 6; t++) begin
         for (int n = 0; n < N; n++)
            if (!port_req[n].req) port_req[n] = rand_payload();
         cycle(0, 64'd0);
         cycle(1, {$urandom, $urandom});
      end
      cycle(0, 64'd0);
      for (int n = 0; n < N; n++) port_req[n].req = 1'b0;
      for (int i = 0; i < 3; i++) cycle(m_busy, {$urandom, $urandom});

      // reset in the second BUSY cycle with rr_ptr away from 0
      port_req[1] = rand_payload();
      cycle(0, 64'd0);
      cycle(0, 64'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("rst_drops_req", req_out.req, 0);
      check("rst_drops_acks", resp_out, 0);
      check("rst_busy", busy, 0);
      check("rst_timeout", tmo, 0);
      for (int n = 0; n < N; n++) begin
         port_req[n].req = 1'b0;
         clear_next[n]   = 1'b0;
         req_in[n]       = port_req[n];
      end
      resp_in = '0;
      m_busy = 0; m_tmo = 0; m_rr = 0; m_wd = 0;
      cur_busy = 0; cur_tmo = 0;
      grant_q.delete();
      ack_q.delete();
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      for (int n = 0; n < N; n++) port_req[n] = rand_payload();
      cycle(0, 64'd0);
      cycle(1, {$urandom, $urandom});

      // randomized traffic
      rand_on = 1;
      for (int i = 0; i < 3000; i++) cycle($urandom_range(0, 99) < 40, {$urandom, $urandom});
      rand_on = 0;
      for (int n = 0; n < N; n++) port_req[n].req = 1'b0;
      for (int i = 0; i < 4; i++) cycle(1, {$urandom, $urandom});
      cycle(0, 64'd0);
      @(posedge clk);
      check("grant_q_drained", grant_q.size(), 0);
      check("ack_q_drained", ack_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
